pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
// - Hazard/stall sequencer for the 5-stage MIPS pipeline; drives stall/flush enables of F/D, D/E, E/M pipeline registers.
// - Resolves forwarding, load-use and branch stalls, multi-cycle data-memory waits, and syscall drain/halt (sysM, regvM).
// - Sits beside the datapath; every pipeline register gains a hold (Stall*) or clear (Flush*) input driven from here.
// PARAMETERS
// - MEM_TIMEOUT   default 16   max cycles in MEM_WAIT before mem_timeout is flagged and HALT is entered
// - EXIT_CODE     default 10   regvM value that makes a syscall halt the core
// - CNT_W         default 32   width of stall_cnt
// PORTS
// - clk         in   1      rising-edge clock
// - rst         in   1      asynchronous, active-high reset
// - rsD,rtD     in   5      D-stage source regs;  rsE,rtE in 5  E-stage source regs
// - WriteRegE/M/W in 5      destination regs per stage;  RegWriteE/M/W in 1  write enables
// - MemtoRegE/M in   1      load in E / M;  MemWriteM in 1  store in M
// - BranchD     in   1      branch compare in D (needs operands in D)
// - sysM        in   1      syscall in M;  regvM in 32  $v0 value with that syscall
// - mem_ready   in   1      data memory has completed the M-stage access this cycle
// - StallF,StallD,StallE,StallM out 1  hold the F, F/D, D/E, E/M registers
// - FlushE,FlushM out 1     clear D/E, E/M to bubble (all controls 0)
// - ForwardAE,ForwardBE out 2  00 regfile, 10 from ALUOutM, 01 from ResultW
// - ForwardAD,ForwardBD out 1  branch-compare operand from ALUOutM
// - halted      out  1      registered; core stopped
// - mem_timeout out  1      registered sticky error flag
// - stall_cnt   out  CNT_W  registered count of cycles with StallF=1 (saturating)
// BEHAVIOUR
// - States: RUN, MEM_WAIT, SYS_DRAIN, HALT. Reset (async): state=RUN, halted=0, mem_timeout=0, stall_cnt=0, wait_cnt=0.
// - Stall/flush/forward outputs are combinational from state+inputs (effective same cycle); halted/mem_timeout/stall_cnt registered.
// - Forwarding: ForwardAE=10 if RegWriteM && WriteRegM!=0 && WriteRegM==rsE; else 01 if same for W; else 00. B likewise with rtE.
//   ForwardAD = RegWriteM && WriteRegM!=0 && WriteRegM==rsD; BD with rtD. $0 never forwarded.
// - lwstall = MemtoRegE && (rtE==rsD || rtE==rtD).
// - brstall = BranchD && ((RegWriteE && WriteRegE!=0 && WriteRegE in {rsD,rtD}) || (MemtoRegM && WriteRegM!=0 && WriteRegM in {rsD,rtD})).
// - RUN: if (MemtoRegM|MemWriteM) && !mem_ready -> MEM_WAIT, this cycle StallF=StallD=StallE=StallM=1, FlushE=FlushM=0.
//   else if sysM -> SYS_DRAIN, latch sys_exit=(regvM==EXIT_CODE); this cycle StallF=StallD=1, FlushE=1.
//   else if lwstall|brstall: StallF=StallD=FlushE=1 (one bubble), stay RUN. else all stalls/flushes 0.
// - MEM_WAIT: all four Stall*=1, no flush; wait_cnt increments each cycle. mem_ready=1 -> RUN, that cycle stalls released (access completes).
//   wait_cnt==MEM_TIMEOUT-1 with !mem_ready -> HALT, mem_timeout<=1. wait_cnt cleared on leaving.
// - SYS_DRAIN (exactly 1 cycle, syscall now in W): StallF=StallD=1, FlushE=1, FlushM=1. Next: sys_exit ? HALT : RUN.
// - HALT: all Stall*=1, FlushE=FlushM=1; halted=1 from the cycle after entry; leaves only via rst.
// - Priority within RUN: mem wait > syscall > lwstall/brstall. Memory-wait and syscall in same cycle: MEM_WAIT first, syscall handled after return.
// - stall_cnt increments on every cycle StallF=1 (including HALT), saturates at all-ones.
// - rst asserted mid-MEM_WAIT/SYS_DRAIN/HALT: immediate return to RUN, counters and flags cleared, stalls drop same cycle.
// STRUCTURE
// - Shared package: state enum (RUN/MEM_WAIT/SYS_DRAIN/HALT), FWD_REG=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01.
// - One sub-module: fwd_unit (purely combinational forwarding muxing selects); FSM, stall logic and counters in the top.
// TESTING
// - Forward: RegWriteM=1,WriteRegM=8,rsE=8, RegWriteW=1,WriteRegW=8 -> ForwardAE=10 (M wins); WriteRegM=0,rsE=0 -> 00.
// - Load-use: MemtoRegE=1,rtE=9,rsD=9 -> StallF=StallD=FlushE=1 for exactly one cycle, stall_cnt +1, state RUN.
// - Mem wait: MemtoRegM=1, mem_ready low 3 cycles then high -> StallM=1 for 3 cycles, release on 4th, stall_cnt +3.
// - Timeout: MemWriteM=1, mem_ready held 0 -> HALT after 16 wait cycles, mem_timeout=1, halted=1 next cycle.
// - Syscall: sysM=1,regvM=4 -> 1 drain cycle (FlushM=1) then RUN; regvM=10 -> HALT, halted=1, all stalls held.
// - Reset mid-HALT: assert rst async -> halted=0, stall_cnt=0, all Stall*/Flush* 0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned FWD_W  = 2;

    localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        SYS_DRAIN = 2'd2,
        HALT      = 2'd3
    } state_e;

    // A later stage writes a non-$0 register that a source operand names.
    function automatic logic reg_hit(
        input logic             we,
        input logic [REG_W-1:0] wr,
        input logic [REG_W-1:0] src
    );
        return we && (wr != '0) && (wr == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational forwarding selects for the E-stage ALU and D-stage branch compare.
module pipe_hazard_ctrl_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic [REG_W-1:0] rs_e,
    input  logic [REG_W-1:0] rt_e,
    input  logic [REG_W-1:0] write_reg_m,
    input  logic [REG_W-1:0] write_reg_w,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    output logic [FWD_W-1:0] fwd_ae_c,
    output logic [FWD_W-1:0] fwd_be_c,
    output logic             fwd_ad_c,
    output logic             fwd_bd_c
);

    // M-stage result is newer than W, so it wins when both match.
    always_comb begin
        fwd_ae_c = FWD_REG;
        fwd_be_c = FWD_REG;
        if (reg_hit(reg_write_m, write_reg_m, rs_e)) begin
            fwd_ae_c = FWD_MEM;
        end else if (reg_hit(reg_write_w, write_reg_w, rs_e)) begin
            fwd_ae_c = FWD_WB;
        end
        if (reg_hit(reg_write_m, write_reg_m, rt_e)) begin
            fwd_be_c = FWD_MEM;
        end else if (reg_hit(reg_write_w, write_reg_w, rt_e)) begin
            fwd_be_c = FWD_WB;
        end
        fwd_ad_c = reg_hit(reg_write_m, write_reg_m, rs_d);
        fwd_bd_c = reg_hit(reg_write_m, write_reg_m, rt_d);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: stall/flush/forward controls,
// data-memory wait with timeout, syscall drain and halt.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned EXIT_CODE   = 10,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  rsD,
    input  logic [REG_W-1:0]  rtD,
    input  logic [REG_W-1:0]  rsE,
    input  logic [REG_W-1:0]  rtE,
    input  logic [REG_W-1:0]  WriteRegE,
    input  logic [REG_W-1:0]  WriteRegM,
    input  logic [REG_W-1:0]  WriteRegW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic              BranchD,
    input  logic              sysM,
    input  logic [DATA_W-1:0] regvM,
    input  logic              mem_ready,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushE,
    output logic              FlushM,
    output logic [FWD_W-1:0]  ForwardAE,
    output logic [FWD_W-1:0]  ForwardBE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic              halted,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned       WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [DATA_W-1:0] EXIT_VAL  = DATA_W'(EXIT_CODE);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               sys_exit_q, sys_exit_d;
    logic               halted_q, halted_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               mem_busy_c;
    logic               lwstall_c;
    logic               brstall_c;

    pipe_hazard_ctrl_fwd_unit u_fwd_unit (
        .rs_d        (rsD),
        .rt_d        (rtD),
        .rs_e        (rsE),
        .rt_e        (rtE),
        .write_reg_m (WriteRegM),
        .write_reg_w (WriteRegW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_ae_c    (ForwardAE),
        .fwd_be_c    (ForwardBE),
        .fwd_ad_c    (ForwardAD),
        .fwd_bd_c    (ForwardBD)
    );

    // Branch operands are needed in D, so an in-flight ALU result in E or a load in M blocks it.
    always_comb begin
        mem_busy_c = (MemtoRegM || MemWriteM) && !mem_ready;
        lwstall_c  = MemtoRegE && ((rtE == rsD) || (rtE == rtD));
        brstall_c  = BranchD &&
                     (reg_hit(RegWriteE, WriteRegE, rsD) || reg_hit(RegWriteE, WriteRegE, rtD) ||
                      reg_hit(MemtoRegM, WriteRegM, rsD) || reg_hit(MemtoRegM, WriteRegM, rtD));
    end

    // Next-state, stall/flush controls and counter updates.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        sys_exit_d    = sys_exit_q;
        mem_timeout_d = mem_timeout_q;
        StallF        = 1'b0;
        StallD        = 1'b0;
        StallE        = 1'b0;
        StallM        = 1'b0;
        FlushE        = 1'b0;
        FlushM        = 1'b0;

        case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (mem_busy_c) begin
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    StallE  = 1'b1;
                    StallM  = 1'b1;
                    state_d = MEM_WAIT;
                end else if (sysM) begin
                    StallF     = 1'b1;
                    StallD     = 1'b1;
                    FlushE     = 1'b1;
                    sys_exit_d = (regvM == EXIT_VAL);
                    state_d    = SYS_DRAIN;
                end else if (lwstall_c || brstall_c) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    wait_cnt_d = '0;
                    state_d    = RUN;
                end else begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        wait_cnt_d    = '0;
                        mem_timeout_d = 1'b1;
                        state_d       = HALT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            SYS_DRAIN: begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                FlushE  = 1'b1;
                FlushM  = 1'b1;
                state_d = sys_exit_q ? HALT : RUN;
            end
            HALT: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushE = 1'b1;
                FlushM = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        halted_d    = (state_q == HALT);
        stall_cnt_d = (StallF && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            sys_exit_q    <= 1'b0;
            halted_q      <= 1'b0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            sys_exit_q    <= sys_exit_d;
            halted_q      <= halted_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign halted      = halted_q;
    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT_CYC = 16;
    localparam int EXIT_VAL    = 10;

    logic        clk;
    logic        rst;
    logic [4:0]  rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW;
    logic        MemtoRegE, MemtoRegM, MemWriteM, BranchD, sysM, mem_ready;
    logic [31:0] regvM;
    logic        StallF, StallD, StallE, StallM, FlushE, FlushM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        ForwardAD, ForwardBD;
    logic        halted, mem_timeout;
    logic [31:0] stall_cnt;

    int n_checks;
    int n_fail;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .BranchD(BranchD), .sysM(sysM), .regvM(regvM), .mem_ready(mem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .halted(halted), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: outstanding-access age, pending drain, halt age, sticky flags.
    int          m_pend;
    bit          m_drain, m_exit, m_halt, m_tmo;
    int          m_age;
    logic [31:0] m_cnt;
    logic [1:0]  e_fae, e_fbe;
    bit          e_fad, e_fbd, e_sf, e_sd, e_se, e_sm, e_fe, e_fm;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input bit we, input logic [4:0] wr, input logic [4:0] src);
        return we && wr != 5'd0 && wr == src;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_drain = 0; m_exit = 0; m_halt = 0; m_tmo = 0; m_age = 0; m_cnt = 32'd0;
    endtask

    task automatic model_comb();
        bit all4, bubble;
        e_fae = hit(RegWriteM, WriteRegM, rsE) ? 2'b10 : hit(RegWriteW, WriteRegW, rsE) ? 2'b01 : 2'b00;
        e_fbe = hit(RegWriteM, WriteRegM, rtE) ? 2'b10 : hit(RegWriteW, WriteRegW, rtE) ? 2'b01 : 2'b00;
        e_fad = hit(RegWriteM, WriteRegM, rsD);
        e_fbd = hit(RegWriteM, WriteRegM, rtD);
        all4 = 0; bubble = 0; e_fm = 0;
        if (m_halt) begin
            all4 = 1; bubble = 1; e_fm = 1;
        end else if (m_drain) begin
            bubble = 1; e_fm = 1;
        end else if (m_pend > 0) begin
            all4 = !mem_ready;
        end else if ((MemtoRegM || MemWriteM) && !mem_ready) begin
            all4 = 1;
        end else if (sysM) begin
            bubble = 1;
        end else if ((MemtoRegE && (rtE == rsD || rtE == rtD)) ||
                     (BranchD && (hit(RegWriteE, WriteRegE, rsD) || hit(RegWriteE, WriteRegE, rtD) ||
                                  hit(MemtoRegM, WriteRegM, rsD) || hit(MemtoRegM, WriteRegM, rtD)))) begin
            bubble = 1;
        end
        e_sf = all4 || bubble;
        e_sd = all4 || bubble;
        e_se = all4;
        e_sm = all4;
        e_fe = bubble;
    endtask

    task automatic model_update();
        model_comb();
        if (e_sf && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (m_halt) begin
            if (m_age < 1000) m_age++;
        end else if (m_drain) begin
            m_drain = 0;
            if (m_exit) begin m_halt = 1; m_age = 0; end
        end else if (m_pend > 0) begin
            if (mem_ready) m_pend = 0;
            else if (m_pend == TIMEOUT_CYC) begin m_pend = 0; m_tmo = 1; m_halt = 1; m_age = 0; end
            else m_pend++;
        end else if ((MemtoRegM || MemWriteM) && !mem_ready) begin
            m_pend = 1;
        end else if (sysM) begin
            m_drain = 1;
            m_exit = (regvM == 32'(EXIT_VAL));
        end
    endtask

    task automatic check_all();
        model_comb();
        check_eq("ForwardAE", 32'(ForwardAE), 32'(e_fae));
        check_eq("ForwardBE", 32'(ForwardBE), 32'(e_fbe));
        check_eq("ForwardAD", 32'(ForwardAD), 32'(e_fad));
        check_eq("ForwardBD", 32'(ForwardBD), 32'(e_fbd));
        check_eq("StallF", 32'(StallF), 32'(e_sf));
        check_eq("StallD", 32'(StallD), 32'(e_sd));
        check_eq("StallE", 32'(StallE), 32'(e_se));
        check_eq("StallM", 32'(StallM), 32'(e_sm));
        check_eq("FlushE", 32'(FlushE), 32'(e_fe));
        check_eq("FlushM", 32'(FlushM), 32'(e_fm));
        check_eq("halted", 32'(halted), 32'(m_halt && m_age >= 1));
        check_eq("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
        check_eq("stall_cnt", stall_cnt, m_cnt);
    endtask

    // Entered at posedge+1; returns at the next posedge+1.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
        WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
        BranchD = 1'b0; sysM = 1'b0; regvM = 32'd0; mem_ready = 1'b1;
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic apply_reset();
        #1;
        clear_inputs();
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_stall_cnt", stall_cnt, 32'd0);
        check_eq("rst_stalls", 32'({StallF, StallD, StallE, StallM, FlushE, FlushM}), 32'd0);
        check_eq("rst_mem_timeout", 32'(mem_timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive_random(input bit stuck);
        rsD = 5'($urandom_range(0, 3));  rtD = 5'($urandom_range(0, 3));
        rsE = 5'($urandom_range(0, 3));  rtE = 5'($urandom_range(0, 3));
        WriteRegE = 5'($urandom_range(0, 3));
        WriteRegM = 5'($urandom_range(0, 3));
        WriteRegW = 5'($urandom_range(0, 3));
        RegWriteE = 1'($urandom_range(0, 1));
        RegWriteM = 1'($urandom_range(0, 1));
        RegWriteW = 1'($urandom_range(0, 1));
        MemtoRegE = ($urandom_range(0, 3) == 0);
        MemtoRegM = ($urandom_range(0, 4) == 0);
        MemWriteM = ($urandom_range(0, 9) == 0);
        BranchD   = ($urandom_range(0, 2) == 0);
        sysM      = ($urandom_range(0, 19) == 0);
        regvM     = ($urandom_range(0, 1) == 1) ? 32'(EXIT_VAL) : 32'($urandom_range(0, 15));
        mem_ready = stuck ? 1'b0 : ($urandom_range(0, 9) < 7);
    endtask

    initial begin
        int c0;
        int stuck_left;
        n_checks = 0;
        n_fail = 0;
        stuck_left = 0;
        clear_inputs();
        model_reset();
        rst = 1'b1;
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_update();
        #1;

        // Forwarding priority and $0 exclusion
        RegWriteM = 1'b1; WriteRegM = 5'd8; rsE = 5'd8; RegWriteW = 1'b1; WriteRegW = 5'd8;
        #1 check_eq("fwd_m_wins", 32'(ForwardAE), 32'h2);
        cycle();
        WriteRegM = 5'd3;
        #1 check_eq("fwd_w", 32'(ForwardAE), 32'h1);
        cycle();
        WriteRegM = 5'd0; rsE = 5'd0;
        #1 check_eq("fwd_zero", 32'(ForwardAE), 32'h0);
        cycle();

        // Load-use bubble
        clear_inputs();
        MemtoRegE = 1'b1; rtE = 5'd9; rsD = 5'd9;
        c0 = int'(m_cnt);
        #1 check_eq("lw_stall", 32'({StallF, StallD, FlushE, StallE}), 32'hE);
        cycle();
        MemtoRegE = 1'b0;
        #1 check_eq("lw_release", 32'(StallF), 32'd0);
        check_eq("lw_cnt", stall_cnt, 32'(c0 + 1));
        cycle();

        // Three-cycle memory wait
        clear_inputs();
        MemtoRegM = 1'b1; mem_ready = 1'b0;
        c0 = int'(m_cnt);
        repeat (3) begin
            #1 check_eq("memwait_stallm", 32'(StallM), 32'd1);
            cycle();
        end
        mem_ready = 1'b1;
        #1 check_eq("memwait_release", 32'(StallM), 32'd0);
        cycle();
        MemtoRegM = 1'b0;
        #1 check_eq("memwait_cnt", stall_cnt, 32'(c0 + 3));
        cycle();

        // Memory timeout then reset out of HALT
        clear_inputs();
        MemWriteM = 1'b1; mem_ready = 1'b0;
        repeat (17) cycle();
        #1 check_eq("tmo_flag", 32'(mem_timeout), 32'd1);
        check_eq("tmo_halted_lag", 32'(halted), 32'd0);
        cycle();
        #1 check_eq("tmo_halted", 32'(halted), 32'd1);
        cycle();
        apply_reset();

        // Syscall without exit, then with exit
        sysM = 1'b1; regvM = 32'd4;
        #1 check_eq("sys_take", 32'({StallF, FlushE, FlushM}), 32'h6);
        cycle();
        sysM = 1'b0;
        #1 check_eq("sys_drain", 32'(FlushM), 32'd1);
        cycle();
        #1 check_eq("sys_resume", 32'({StallF, FlushM}), 32'd0);
        cycle();
        sysM = 1'b1; regvM = 32'd10;
        cycle();
        sysM = 1'b0;
        cycle();
        cycle();
        #1 check_eq("sys_halted", 32'({halted, StallF, StallD, StallE, StallM}), 32'h1F);
        cycle();
        apply_reset();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ((m_halt && m_age > 3) || $urandom_range(0, 299) == 0) begin
                apply_reset();
            end else begin
                if (stuck_left > 0) stuck_left--;
                else if ($urandom_range(0, 99) == 0) stuck_left = 20;
                drive_random(stuck_left > 0);
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
